sample_delay_pipe: RTL and testbench

- Parametrised, elastic, signed-sample pipeline register.
- Generalises the single 12-bit signed D->Q stage to DEPTH stages of WIDTH bits.
- Adds per-stage valid tracking, valid/ready backpressure with bubble collapsing, synchronous flush and an occupancy count.
- Sits between DNA datapath blocks that need a fixed nominal delay, and tolerates downstream stalls without losing samples.

---
 rtl/sample_delay_pipe.sv | 126 ++++++++++++
 tb/tb_sample_delay_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_delay_pipe.sv
// sample_delay_pipe: elastic DEPTH-stage pipeline register for signed WIDTH-bit samples.
// Each stage keeps its own valid bit. Empty stages absorb their predecessor even while
// the output is stalled. The pipe supports a synchronous flush and keeps an occupancy
// count of the valid stages.
// Optional feature: define SAMPLE_DELAY_PIPE_DROP_EN to add drop_cnt. This is a
// saturating 8-bit count of cycles in which upstream offered a sample that was refused.
module sample_delay_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WIDTH-1:0]           in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [WIDTH-1:0]           out_data,
  input  logic                              flush,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
`ifdef SAMPLE_DELAY_PIPE_DROP_EN
  ,
  output logic [7:0]                        drop_cnt
`endif
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic signed [WIDTH-1:0] data_q   [DEPTH];
  logic signed [WIDTH-1:0] data_d   [DEPTH];
  logic signed [WIDTH-1:0] up_data  [DEPTH];
  logic [DEPTH-1:0]        up_valid;
  logic [DEPTH-1:0]        rdy;
  logic                    rdy_chain;
  logic [OccW-1:0]         occ_q, occ_d;
  logic                    in_xfer, out_xfer;

  // Ready ripples back from the output. A stage can load if it is empty or its
  // successor can load.
  always_comb begin
    rdy       = '0;
    rdy_chain = out_ready && !flush;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy_chain = !valid_q[i] || rdy_chain;
      rdy[i]    = rdy_chain;
    end
  end

  // The upstream of stage 0 is the input port. Every other stage's upstream is its predecessor.
  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = valid_q[DEPTH-1] && !flush;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Stage next-state. Data only moves when a valid sample arrives, so bubbles keep old data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          valid_d[i] = up_valid[i];
          if (up_valid[i]) data_d[i] = up_data[i];
        end
      end
    end
  end

  // Occupancy tracks net transfers. A simultaneous accept and emit leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Pipeline state with synchronous active-low reset that overrides flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
    end
  end

`ifdef SAMPLE_DELAY_PIPE_DROP_EN
  logic [7:0] drop_q, drop_d;

  // Count refused offers. Flush cycles count too. The count saturates at 255.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Drop counter register. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= 8'd0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_sample_delay_pipe.sv
// Testbench for sample_delay_pipe (WIDTH=12, DEPTH=4).
// The reference model keeps a queue of accepted samples, each tagged with its accept cycle.
// - The head sample is visible at the output once it is DEPTH cycles old.
// - The pipe refuses input only when it is full with the output stalled.
// Directed sequences add literal expectations on top of the model.
module tb_sample_delay_pipe;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    flush;
  logic [2:0]              occupancy;
`ifdef SAMPLE_DELAY_PIPE_DROP_EN
  logic [7:0]              drop_cnt;
`endif

  sample_delay_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .occupancy(occupancy)
`ifdef SAMPLE_DELAY_PIPE_DROP_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int mq_data[$];
  int mq_t[$];
  int cyc    = 0;
  int m_drop = 0;
  bit known  = 1'b0;
  bit m_xin, m_xout, m_rdy;

  function automatic bit m_in_ready();
    return !flush && ((mq_data.size() < DEPTH) || out_ready);
  endfunction

  function automatic bit m_out_valid();
    if (flush || mq_data.size() == 0) return 1'b0;
    return (cyc - mq_t[0]) >= DEPTH;
  endfunction

  // Model update on every active edge.
  always @(posedge clk) begin
    m_rdy  = m_in_ready();
    m_xin  = in_valid && m_rdy;
    m_xout = m_out_valid() && out_ready;
    if (!rst_n) begin
      mq_data.delete();
      mq_t.delete();
      m_drop = 0;
      known  = 1'b1;
    end else begin
      if (in_valid && !m_rdy && m_drop < 255) m_drop++;
      if (flush) begin
        mq_data.delete();
        mq_t.delete();
      end else begin
        if (m_xout) begin
          void'(mq_data.pop_front());
          void'(mq_t.pop_front());
        end
        if (m_xin) begin
          mq_data.push_back(int'(in_data));
          mq_t.push_back(cyc);
        end
      end
    end
    cyc++;
  end

  // Compare process: DUT against the model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (known) begin
      check("in_ready", int'(in_ready), int'(m_in_ready()));
      check("out_valid", int'(out_valid), int'(m_out_valid()));
      check("occupancy", int'(occupancy), mq_data.size());
      if (m_out_valid()) check("out_data", int'(out_data), mq_data[0]);
`ifdef SAMPLE_DELAY_PIPE_DROP_EN
      check("drop_cnt", int'(drop_cnt), m_drop);
`endif
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  int vals[4] = '{-2048, -1, 0, 2047};
  int got[$];
  int nxt;
  bit xin;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    next();
    next();
    rst_n = 1'b1;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_occupancy", int'(occupancy), 0);
    next();

    // Stream extremes back to back. They must come out on cycles 4..7.
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? WIDTH'(vals[c]) : '0;
      #2;
      if (c == 3) check("stream_early", int'(out_valid), 0);
      if (c >= 4 && c <= 7) begin
        check("stream_valid", int'(out_valid), 1);
        check("stream_data", int'(out_data), vals[c-4]);
      end
      if (c == 4) check("stream_occ_peak", int'(occupancy), 4);
      next();
    end

    // Backpressure fill: exactly DEPTH accepts, then refusal.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = (c < 4) ? WIDTH'(c + 1) : WIDTH'(5);
      #2;
      check("bp_in_ready", int'(in_ready), int'(c < 4));
      if (c >= 4) check("bp_occ_full", int'(occupancy), 4);
      next();
    end
    out_ready = 1'b1;
    nxt = 5;
    got.delete();
    for (int c = 0; c < 15; c++) begin
      in_valid = (nxt <= 6);
      in_data  = WIDTH'(nxt);
      #2;
      if (c == 0) begin
        check("full_in_ready", int'(in_ready), 1);
        check("full_out_valid", int'(out_valid), 1);
        check("full_out_data", int'(out_data), 1);
        check("full_occ", int'(occupancy), 4);
      end
      if (c == 1) check("full_occ_hold", int'(occupancy), 4);
      xin = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(int'(out_data));
      next();
      if (xin) nxt++;
    end
    check("bp_out_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) check("bp_out_order", got[k], k + 1);
    in_valid = 1'b0;
    #2;
    check("empty_occ", int'(occupancy), 0);
    next();
    #2;
    check("empty_occ_hold", int'(occupancy), 0);
    next();

    // Bubbles: inputs on cycles 0 and 3 only.
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0 || c == 3);
      in_data  = WIDTH'(100 + c);
      #2;
      check("bub_valid", int'(out_valid), int'(c == 4 || c == 7));
      if (c == 4) check("bub_data0", int'(out_data), 100);
      if (c == 7) check("bub_data1", int'(out_data), 103);
      if (c == 4) check("bub_occ4", int'(occupancy), 2);
      if (c == 5) check("bub_occ5", int'(occupancy), 1);
      if (c == 8) check("bub_occ8", int'(occupancy), 0);
      next();
    end

    // Flush mid-stream with three samples held and the head at the output stage.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = WIDTH'(10 + k);
      next();
    end
    in_valid = 1'b0;
    next();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = WIDTH'(99);
    #2;
    check("flush_in_ready", int'(in_ready), 0);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_occ_before", int'(occupancy), 3);
    next();
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data   = 12'sh5A5;
    #2;
    check("flush_occ_after", int'(occupancy), 0);
    check("flush_in_ready_after", int'(in_ready), 1);
    next();
    in_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      #2;
      check("flush_new_valid", int'(out_valid), int'(c == 4));
      if (c == 4) check("flush_new_data", int'(out_data), 32'h5A5);
      next();
    end

    // Reset mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = WIDTH'(7 + k);
      next();
    end
    in_valid = 1'b0;
    #2;
    check("mid_occ", int'(occupancy), 3);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    #2;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_occ", int'(occupancy), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    next();

    // Mixed traffic with occasional flush. The model does the checking.
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 23) == 0;
      in_data   = WIDTH'($urandom);
      next();
    end
    flush = 1'b0;

`ifdef SAMPLE_DELAY_PIPE_DROP_EN
    rst_n    = 1'b0;
    in_valid = 1'b0;
    next();
    rst_n = 1'b1;
    #2;
    check("drop_rst", int'(drop_cnt), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = WIDTH'(k);
      next();
    end
    for (int k = 0; k < 300; k++) begin
      in_data = WIDTH'(k);
      #2;
      if (k == 10) check("drop_mid", int'(drop_cnt), 10);
      next();
    end
    check("drop_sat", int'(drop_cnt), 255);
    flush = 1'b1;
    next();
    next();
    flush = 1'b0;
    #2;
    check("drop_after_flush", int'(drop_cnt), 255);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    #2;
    check("drop_after_rst", int'(drop_cnt), 0);
    next();
`endif

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
